qerv_rf_ram_arb: RTL
====================

Name: qerv_rf_ram_arb

Overview:
- Shares the single register-file RAM (serv_rf_ram) between two requesters.
  - The core's qerv_rf_ram_if (primary) has absolute priority.
  - A 32-bit register-granular side port (debug / boot-loader / test access) runs only in free cycles.
- Sits between qerv_rf_ram_if and serv_rf_ram inside the RF top level.
- Serialises each side-port access into 32/RF_WIDTH RAM words and reassembles read data.
- Shields the core's read-data view from side-port reads.

Parameters:
- WITH_CSR, 1, adds 4 CSR registers to the register space; register index is 5+WITH_CSR bits wide.
- RF_WIDTH, 8, RAM word width. Legal values: 2, 4, 8, 16, 32.
- RF_L2D, $clog2((32+WITH_CSR*4)*32/RF_WIDTH), RAM address width.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_core_waddr  in  RF_L2D  core write address
- i_core_wdata  in  RF_WIDTH  core write data
- i_core_wen  in  1  core write enable
- i_core_raddr  in  RF_L2D  core read address
- i_core_ren  in  1  core read enable
- o_core_rdata  out  RF_WIDTH  core read data
- o_ram_waddr  out  RF_L2D  RAM write address
- o_ram_wdata  out  RF_WIDTH  RAM write data
- o_ram_wen  out  1  RAM write enable
- o_ram_raddr  out  RF_L2D  RAM read address
- o_ram_ren  out  1  RAM read enable
- i_ram_rdata  in  RF_WIDTH  RAM read data, valid the cycle after o_ram_ren
- i_side_req  in  1  side-port request
- i_side_we  in  1  1 = write, 0 = read
- i_side_reg  in  5+WITH_CSR  register index
- i_side_wdata  in  32  write data
- o_side_rdata  out  32  read data, valid with o_side_ack
- o_side_ack  out  1  one-cycle completion pulse
- o_side_busy  out  1  high from request accept until ack

Behaviour:
- Interface: single clock clk. Reset i_rst_n is synchronous and active-low.
- Reset values: state IDLE, word counter 0, o_side_ack 0, o_side_busy 0, o_side_rdata 0, shadow 0.
- Core path is zero-latency combinational:
  - When i_core_wen or i_core_ren is high, the core's addresses, data and enables drive the RAM ports that cycle.
  - Core read and write in the same cycle pass through together.
- Free cycle: i_core_wen=0 and i_core_ren=0. Only in a free cycle may the FSM drive the RAM (one word read or one word write).
- Core read-data isolation:
  - Registered flag core_rd_d = i_core_ren delayed one cycle.
  - If core_rd_d=1, o_core_rdata = i_ram_rdata, and the shadow register captures i_ram_rdata.
  - Otherwise o_core_rdata = shadow.
  - Side-port reads therefore never disturb the data the core sees.
- Address mapping: RAM address = {reg, word}, where word = 0..N-1, N = 32/RF_WIDTH. Word 0 holds bits RF_WIDTH-1:0 (LSB first).
- FSM states: IDLE, XFER, RDLAST, ACK.
  - IDLE: on i_side_req=1, latch we, reg and wdata, clear the counter, set busy, go to XFER.
  - Register 0: x0 write is acked with no RAM write; x0 read returns 0 with no RAM read. In both cases go directly to ACK.
  - XFER: in each free cycle, issue word[cnt] and increment cnt. Stalled cycles hold cnt.
    - For a read, the data of the word issued in cycle t is captured at t+1 into o_side_rdata[cnt*RF_WIDTH +: RF_WIDTH] via a delayed index.
    - After word N-1 is issued: a write goes to ACK; a read goes to RDLAST.
  - RDLAST: capture the final word, go to ACK.
  - ACK: o_side_ack=1 for one cycle, busy cleared, go to IDLE. A request seen in IDLE the next cycle starts a new transaction.
- Latency with no contention, from accept to ack cycle:
  - write: N+1 cycles
  - read: N+2 cycles
  - each busy core cycle adds 1.
- No side-port starvation guarantee: the core always wins.
- Side inputs must stay stable until ack; they are only sampled in IDLE.
- Reset mid-transaction: return to IDLE with no ack. RAM words already written stay written; the register may hold mixed data.

Decomposition:
- Shared package: state encoding for IDLE/XFER/RDLAST/ACK, and localparams N and word-index width ($clog2(N), minimum 1).
- Sub-module: qerv_rf_word_pack, a shift/insert register that assembles and disassembles 32-bit values into RF_WIDTH words. It is reused by the side-port write data path and the read data path.

Test Plan:
- Idle core, RF_WIDTH=8, side write reg 5 = 0xDEADBEEF:
  - RAM writes at {5,0..3} = EF, BE, AD, DE in 4 consecutive cycles.
  - Ack on cycle 5.
- Then side read reg 5 -> 4 RAM reads, o_side_rdata = 0xDEADBEEF with ack on cycle 6.
- Core ren on alternate cycles during a side read -> side issues only in gaps, latency 10 cycles, data still correct.
- Core reads word A (value 0x3C), then a side read runs for 4 cycles -> o_core_rdata holds 0x3C throughout.
- Side write to x0 with wdata 0xFFFFFFFF -> no o_ram_wen, ack after 1 cycle. Side read of x0 -> o_side_rdata = 0.
- Deassert i_rst_n mid-XFER after 2 of 4 words -> next cycle IDLE, busy=0, no ack. Only words 0..1 were written.

Source files
------------

// File: rtl/qerv_rf_ram_arb_pkg.sv
// Shared definitions for the register-file RAM arbiter: side-port FSM states
// and word-count helpers derived from the RAM word width.
package qerv_rf_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    RDLAST = 2'd2,
    ACK    = 2'd3
  } side_state_e;

  localparam int REG_W = 32;

  // RAM words per 32-bit register (N)
  function automatic int words_per_reg(input int rf_width);
    return REG_W / rf_width;
  endfunction

  // Word-index width, never narrower than one bit
  function automatic int word_idx_w(input int rf_width);
    return (REG_W / rf_width > 1) ? $clog2(REG_W / rf_width) : 1;
  endfunction

endpackage

// File: rtl/qerv_rf_ram_arb_word_pack.sv
// 32-bit pack register: bulk-loaded with a whole register value, or filled one
// RF_WIDTH word at a time at an arbitrary word index.
module qerv_rf_word_pack
  import qerv_rf_ram_arb_pkg::*;
#(
  parameter int RF_WIDTH = 8,
  parameter int IDX_W    = word_idx_w(RF_WIDTH)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [REG_W-1:0]    i_load_data,
  input  logic                i_ins,
  input  logic [IDX_W-1:0]    i_ins_idx,
  input  logic [RF_WIDTH-1:0] i_ins_data,
  output logic [REG_W-1:0]    o_data
);

  logic [REG_W-1:0] data_q;

  // Load wins over insert so a new transaction always starts from a clean value
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      data_q <= '0;
    end else if (i_load) begin
      data_q <= i_load_data;
    end else if (i_ins) begin
      data_q[i_ins_idx*RF_WIDTH +: RF_WIDTH] <= i_ins_data;
    end
  end

  assign o_data = data_q;

endmodule

// File: rtl/qerv_rf_ram_arb.sv
// Register-file RAM arbiter: the core path passes straight through, a 32-bit
// side port is serialised into RAM words during cycles the core leaves free.
module qerv_rf_ram_arb
  import qerv_rf_ram_arb_pkg::*;
#(
  parameter int WITH_CSR = 1,
  parameter int RF_WIDTH = 8,
  parameter int RF_L2D   = $clog2((32 + WITH_CSR*4) * 32 / RF_WIDTH)
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [RF_L2D-1:0]     i_core_waddr,
  input  logic [RF_WIDTH-1:0]   i_core_wdata,
  input  logic                  i_core_wen,
  input  logic [RF_L2D-1:0]     i_core_raddr,
  input  logic                  i_core_ren,
  output logic [RF_WIDTH-1:0]   o_core_rdata,
  output logic [RF_L2D-1:0]     o_ram_waddr,
  output logic [RF_WIDTH-1:0]   o_ram_wdata,
  output logic                  o_ram_wen,
  output logic [RF_L2D-1:0]     o_ram_raddr,
  output logic                  o_ram_ren,
  input  logic [RF_WIDTH-1:0]   i_ram_rdata,
  input  logic                  i_side_req,
  input  logic                  i_side_we,
  input  logic [4+WITH_CSR:0]   i_side_reg,
  input  logic [31:0]           i_side_wdata,
  output logic [31:0]           o_side_rdata,
  output logic                  o_side_ack,
  output logic                  o_side_busy
);

  localparam int N         = words_per_reg(RF_WIDTH);
  localparam int IDX_W     = word_idx_w(RF_WIDTH);
  localparam int REG_IDX_W = 5 + WITH_CSR;

  side_state_e            state;
  logic [IDX_W-1:0]       cnt;
  logic                   we_q;
  logic [REG_IDX_W-1:0]   reg_q;
  logic                   rd_vld_p1;
  logic [IDX_W-1:0]       rd_idx_p1;
  logic                   core_rd_d;
  logic [RF_WIDTH-1:0]    shadow;
  logic [31:0]            wr_data;
  logic                   core_busy;
  logic                   side_issue;
  logic                   accept;
  logic                   last_word;
  logic [RF_L2D-1:0]      side_addr;
  logic [RF_WIDTH-1:0]    side_wword;

  assign core_busy  = i_core_wen | i_core_ren;
  // Reset blocks the side port combinationally so an aborted write stops at once
  assign side_issue = i_rst_n && (state == XFER) && !core_busy;
  assign accept     = (state == IDLE) && i_side_req;
  assign last_word  = (cnt == IDX_W'(N - 1));
  assign side_addr  = RF_L2D'(reg_q) * RF_L2D'(N) + RF_L2D'(cnt);
  assign side_wword = wr_data[cnt*RF_WIDTH +: RF_WIDTH];

  always_comb begin
    if (core_busy) begin
      o_ram_waddr = i_core_waddr;
      o_ram_wdata = i_core_wdata;
      o_ram_wen   = i_core_wen;
      o_ram_raddr = i_core_raddr;
      o_ram_ren   = i_core_ren;
    end else begin
      o_ram_waddr = side_addr;
      o_ram_wdata = side_wword;
      o_ram_wen   = side_issue & we_q;
      o_ram_raddr = side_addr;
      o_ram_ren   = side_issue & ~we_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_side_ack  <= 1'b0;
      o_side_busy <= 1'b0;
      rd_vld_p1   <= 1'b0;
      core_rd_d   <= 1'b0;
    end else begin
      o_side_ack <= 1'b0;
      rd_vld_p1  <= side_issue & ~we_q;
      core_rd_d  <= i_core_ren;
      case (state)
        IDLE: begin
          if (i_side_req) begin
            cnt         <= '0;
            o_side_busy <= 1'b1;
            // x0 is hardwired zero: nothing to move through the RAM
            if (i_side_reg == '0) begin
              state      <= ACK;
              o_side_ack <= 1'b1;
            end else begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (!core_busy) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              if (we_q) begin
                state      <= ACK;
                o_side_ack <= 1'b1;
              end else begin
                state <= RDLAST;
              end
            end
          end
        end
        RDLAST: begin
          state      <= ACK;
          o_side_ack <= 1'b1;
        end
        ACK: begin
          state       <= IDLE;
          o_side_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: read word index follows the issued RAM read by one cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q  <= i_side_we;
      reg_q <= i_side_reg;
    end
    rd_idx_p1 <= cnt;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      shadow <= '0;
    end else if (core_rd_d) begin
      shadow <= i_ram_rdata;
    end
  end

  assign o_core_rdata = core_rd_d ? i_ram_rdata : shadow;

  qerv_rf_word_pack #(.RF_WIDTH(RF_WIDTH), .IDX_W(IDX_W)) u_wr_pack (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_load      (accept),
    .i_load_data (i_side_wdata),
    .i_ins       (1'b0),
    .i_ins_idx   ({IDX_W{1'b0}}),
    .i_ins_data  ({RF_WIDTH{1'b0}}),
    .o_data      (wr_data)
  );

  qerv_rf_word_pack #(.RF_WIDTH(RF_WIDTH), .IDX_W(IDX_W)) u_rd_pack (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_load      (accept),
    .i_load_data (32'h0),
    .i_ins       (rd_vld_p1),
    .i_ins_idx   (rd_idx_p1),
    .i_ins_data  (i_ram_rdata),
    .o_data      (o_side_rdata)
  );

endmodule
